// File: rtl/quad_zoom_pkg.sv
// quad_zoom_pkg: shared state type and constant helpers for the zoom-out filter
package quad_zoom_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} zoom_state_t;
  function automatic int zoom_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) == v) r = i;
    return r;
  endfunction
endpackage

// File: rtl/zoom_frame_ram.sv
// zoom_frame_ram: simple dual-port frame store with a registered read port
module zoom_frame_ram #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/quad_zoom_out.sv
// quad_zoom_out: box-average shrink into a frame RAM, replayed centred inside a constant border
module quad_zoom_out
  import quad_zoom_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ZOOM = 2,
  parameter logic [7:0] BORDER_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_in,
  input  logic       pixel_in_valid,
  output logic [7:0] pixel_out,
  output logic       pixel_out_valid,
  output logic       busy
);
  localparam int LZ = zoom_log2(ZOOM);
  localparam int AW = 8 + 2 * LZ;
  localparam int SW = IMG_WIDTH / ZOOM;
  localparam int SH = IMG_HEIGHT / ZOOM;
  localparam int X_OFF = (IMG_WIDTH - SW) / 2;
  localparam int Y_OFF = (IMG_HEIGHT - SH) / 2;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int SXW = $clog2(SW);
  localparam int RAW = $clog2(SW * SH);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_LO = XW'(X_OFF);
  localparam logic [XW-1:0] X_HI = XW'(X_OFF + SW - 1);
  localparam logic [YW-1:0] Y_LO = YW'(Y_OFF);
  localparam logic [YW-1:0] Y_HI = YW'(Y_OFF + SH - 1);

  if ((ZOOM != 2 && ZOOM != 4 && ZOOM != 8) || IMG_WIDTH % ZOOM != 0 || IMG_HEIGHT % ZOOM != 0) begin : g_bad_param
    $error("quad_zoom_out: ZOOM must be 2, 4 or 8 and divide both frame dimensions");
  end

  zoom_state_t state, state_n;
  logic [XW-1:0] x, ox, rx;
  logic [YW-1:0] y, oy, ry;
  logic [SXW-1:0] xs;
  logic [YW-LZ-1:0] ys;
  logic [AW-1:0] acc [SW];
  logic [AW-1:0] sum;
  logic accept, in_last, out_last, blk_first, blk_last, in_win, win_d;
  logic [RAW-1:0] waddr, raddr;
  logic [7:0] wdata, rdata, last_px;

  assign busy = state == EMIT || pixel_out_valid;
  assign accept = pixel_in_valid && !busy;
  assign in_last = x == X_MAX && y == Y_MAX;
  assign out_last = ox == X_MAX && oy == Y_MAX;

  always_ff @(posedge clk) state <= reset ? IDLE : state_n;

  always_comb begin
    state_n = state == EMIT ? (out_last ? IDLE : EMIT) :
              accept ? (in_last ? EMIT : ACCUM) : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      ox <= '0;
      oy <= '0;
    end else begin
      if (accept) begin
        x <= x == X_MAX ? '0 : x + 1'b1;
        if (x == X_MAX) y <= y == Y_MAX ? '0 : y + 1'b1;
      end
      if (state == EMIT) begin
        ox <= ox == X_MAX ? '0 : ox + 1'b1;
        if (ox == X_MAX) oy <= oy == Y_MAX ? '0 : oy + 1'b1;
      end
    end
  end

  // The first pixel of each block overwrites its slot, so stale sums never need clearing
  assign xs = x[XW-1:LZ];
  assign ys = y[YW-1:LZ];
  assign sum = acc[xs] + AW'(pixel_in);
  assign blk_first = x[LZ-1:0] == '0 && y[LZ-1:0] == '0;
  assign blk_last = &x[LZ-1:0] && &y[LZ-1:0];
  assign wdata = 8'(sum >> (2 * LZ));
  assign waddr = RAW'(int'(ys) * SW + int'(xs));

  always_ff @(posedge clk) if (accept) acc[xs] <= blk_first ? AW'(pixel_in) : sum;

  assign in_win = ox >= X_LO && ox <= X_HI && oy >= Y_LO && oy <= Y_HI;
  assign rx = ox - X_LO;
  assign ry = oy - Y_LO;
  assign raddr = in_win ? RAW'(int'(ry) * SW + int'(rx)) : '0;

  zoom_frame_ram #(.DEPTH(SW * SH), .ADDR_W(RAW)) u_ram (
    .clk  (clk),
    .we   (accept && blk_last),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  // in-window flag travels with the one-cycle RAM read so border and RAM data line up
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out_valid <= 1'b0;
      win_d <= 1'b0;
      last_px <= '0;
    end else begin
      pixel_out_valid <= state == EMIT;
      win_d <= in_win;
      if (pixel_out_valid) last_px <= pixel_out;
    end
  end

  assign pixel_out = !pixel_out_valid ? last_px : win_d ? rdata : BORDER_VAL;
endmodule

// File: tb/tb_quad_zoom_out.sv
// tb_quad_zoom_out: directed checks of the 8x4, zoom 2 shrink with a border of 7
module tb_quad_zoom_out;
  localparam int W = 8;
  localparam int H = 4;
  localparam int T = W * H;
  localparam logic [7:0] BV = 8'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pixel_in = '0;
  logic pixel_in_valid = 1'b0;
  logic [7:0] pixel_out;
  logic pixel_out_valid, busy;

  quad_zoom_out #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ZOOM(2), .BORDER_VAL(BV)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0, fails = 0;
  logic [7:0] img [T];
  logic [7:0] exp_f [T];
  logic [7:0] ref_f [T];
  logic [7:0] out_buf [T];
  int n_out = 0, first_cyc = -1, last_cyc = -1, busy_cnt = 0, last_acc = 0;

  always @(negedge clk) begin
    if (pixel_out_valid) begin
      if (n_out < T) out_buf[n_out] = pixel_out;
      if (n_out == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_out++;
    end
    if (busy) busy_cnt++;
  end

  function automatic void model();
    for (int i = 0; i < T; i++) begin
      int ox, oy, bx, by, s;
      ox = i % W;
      oy = i / W;
      if (ox >= 2 && ox <= 5 && oy >= 1 && oy <= 2) begin
        bx = 2 * (ox - 2);
        by = 2 * (oy - 1);
        s = img[by*W+bx] + img[by*W+bx+1] + img[(by+1)*W+bx] + img[(by+1)*W+bx+1];
        exp_f[i] = 8'(s / 4);
      end else exp_f[i] = BV;
    end
  endfunction

  task automatic clear_mon();
    n_out = 0;
    busy_cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic fill(input int mode, input logic [7:0] v);
    for (int i = 0; i < T; i++) img[i] = mode == 1 ? 8'(i) : v;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < T; i++) begin
      pixel_in = img[i];
      pixel_in_valid = 1'b1;
      if (i == T - 1) last_acc = cyc;
      @(negedge clk);
      if (gaps) begin
        pixel_in_valid = 1'b0;
        pixel_in = 8'hEE;
        @(negedge clk);
      end
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while ((n_out < T || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k >= 300) begin
      fails++;
      $display("FAIL %s timeout: outputs %0d, required %0d", nm, n_out, T);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (pixel_out !== 8'd0) begin fails++; $display("FAIL reset pixel_out got %0d exp 0", pixel_out); end
    tests++; if (pixel_out_valid !== 1'b0) begin fails++; $display("FAIL reset valid got %b exp 0", pixel_out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b exp 0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constant();
    int n100;
    fill(0, 8'd100);
    model();
    clear_mon();
    send_frame(0);
    wait_done("constant");
    tests++; if (n_out !== T) begin fails++; $display("FAIL constant count got %0d exp %0d", n_out, T); end
    n100 = 0;
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL constant px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
      if (out_buf[i] == 8'd100) n100++;
    end
    tests++; if (n100 !== 8) begin fails++; $display("FAIL constant window count got %0d exp 8", n100); end
    tests++; if (first_cyc - last_acc !== 2) begin fails++; $display("FAIL constant latency got %0d exp 2", first_cyc - last_acc); end
    tests++; if (last_cyc - first_cyc !== T - 1) begin fails++; $display("FAIL constant valid span got %0d exp %0d", last_cyc - first_cyc, T - 1); end
    tests++; if (busy_cnt !== T + 1) begin fails++; $display("FAIL constant busy cycles got %0d exp %0d", busy_cnt, T + 1); end
  endtask

  task automatic test_trunc();
    fill(0, 8'd0);
    img[0] = 8'd1; img[1] = 8'd2; img[8] = 8'd3; img[9] = 8'd5;
    img[2] = 8'd255; img[3] = 8'd255; img[10] = 8'd255; img[11] = 8'd255;
    model();
    clear_mon();
    send_frame(0);
    wait_done("trunc");
    tests++; if (out_buf[10] !== 8'd2) begin fails++; $display("FAIL trunc avg got %0d exp 2", out_buf[10]); end
    tests++; if (out_buf[11] !== 8'd255) begin fails++; $display("FAIL trunc sat got %0d exp 255", out_buf[11]); end
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL trunc px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
    end
  endtask

  task automatic test_gaps();
    fill(1, 8'd0);
    model();
    clear_mon();
    send_frame(0);
    wait_done("ramp");
    for (int i = 0; i < T; i++) begin
      ref_f[i] = out_buf[i];
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL ramp px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
    end
    tests++; if (out_buf[10] !== 8'd4) begin fails++; $display("FAIL ramp (2,1) got %0d exp 4", out_buf[10]); end
    tests++; if (out_buf[21] !== 8'd26) begin fails++; $display("FAIL ramp (5,2) got %0d exp 26", out_buf[21]); end
    clear_mon();
    send_frame(1);
    wait_done("gaps");
    tests++; if (n_out !== T) begin fails++; $display("FAIL gaps count got %0d exp %0d", n_out, T); end
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== ref_f[i]) begin fails++; $display("FAIL gaps px%0d got %0d exp %0d", i, out_buf[i], ref_f[i]); end
    end
    tests++; if (first_cyc - last_acc !== 2) begin fails++; $display("FAIL gaps latency got %0d exp 2", first_cyc - last_acc); end
  endtask

  task automatic test_back_to_back();
    int k;
    fill(1, 8'd0);
    model();
    clear_mon();
    send_frame(0);
    pixel_in = 8'd200;
    pixel_in_valid = 1'b1;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    tests++; if (k >= 300) begin fails++; $display("FAIL b2b busy stuck got 1 exp 0"); end
    tests++; if (n_out !== T) begin fails++; $display("FAIL b2b first count got %0d exp %0d", n_out, T); end
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL b2b first px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
    end
    fill(0, 8'd50);
    model();
    clear_mon();
    send_frame(0);
    wait_done("b2b");
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL b2b second px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int k;
    fill(0, 8'd222);
    clear_mon();
    send_frame(0);
    k = 0;
    while (n_out < 3 && k < 300) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (pixel_out_valid !== 1'b0) begin fails++; $display("FAIL emit-reset valid got %b exp 0", pixel_out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL emit-reset busy got %b exp 0", busy); end
    tests++; if (pixel_out !== 8'd0) begin fails++; $display("FAIL emit-reset pixel_out got %0d exp 0", pixel_out); end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      pixel_in = 8'd222;
      pixel_in_valid = 1'b1;
      @(negedge clk);
    end
    pixel_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests++; if (pixel_out_valid !== 1'b0) begin fails++; $display("FAIL accum-reset valid got %b exp 0", pixel_out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL accum-reset busy got %b exp 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    fill(0, 8'd9);
    model();
    clear_mon();
    send_frame(0);
    wait_done("reset");
    tests++; if (n_out !== T) begin fails++; $display("FAIL reset frame count got %0d exp %0d", n_out, T); end
    for (int i = 0; i < T; i++) begin
      tests++;
      if (out_buf[i] !== exp_f[i]) begin fails++; $display("FAIL reset frame px%0d got %0d exp %0d", i, out_buf[i], exp_f[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_trunc();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end
endmodule
